// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_seq_pkg;

    localparam int LEN_DEF = 16;
    localparam int CNT_W_DEF = $clog2(LEN_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Radix-2 sequential unsigned multiplier: Y = (A*B) mod 2^LEN, one multiplier bit per clock.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [LEN-1:0] A,
    input  logic [LEN-1:0] B,
    output logic           DONE,
    output logic [LEN-1:0] Y
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(LEN - 1);

    state_t         r_state;
    logic [LEN-1:0] r_mcand;
    logic [LEN-1:0] r_mplier;
    logic [LEN-1:0] r_acc;
    logic [CW-1:0]  r_count;
    logic           r_done;

    // FSM and shift-add datapath; START restarts from any state, RST overrides everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_mcand  <= {LEN{1'b0}};
            r_mplier <= {LEN{1'b0}};
            r_acc    <= {LEN{1'b0}};
            r_count  <= {CW{1'b0}};
            r_done   <= 1'b0;
        end else if (START) begin
            r_state  <= BUSY;
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= {LEN{1'b0}};
            r_count  <= {CW{1'b0}};
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end else begin
                        r_acc <= r_acc;
                    end
                    r_mcand  <= {r_mcand[LEN-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[LEN-1:1]};
                    r_count  <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    // Last of the LEN steps: result complete on this edge
                    if (r_count == LAST_STEP) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= BUSY;
                        r_done  <= 1'b0;
                    end
                end
                IDLE, FIN: begin
                    r_state <= r_state;
                    r_done  <= r_done;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign DONE = r_done;
    assign Y    = r_acc;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed table, multi-cycle corner cases, random ops vs model.
module tb_mul_seq;

    localparam int LEN = 16;
    localparam int STEPS = LEN;

    logic           CLK;
    logic           RST;
    logic           START;
    logic [LEN-1:0] A;
    logic [LEN-1:0] B;
    logic           DONE;
    logic [LEN-1:0] Y;

    int n_vec;
    int n_err;

    typedef struct {
        string          name;
        logic [LEN-1:0] a;
        logic [LEN-1:0] b;
        logic [LEN-1:0] y;
    } vec_t;

    vec_t vecs [4];

    mul_seq #(.LEN(LEN)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .DONE  (DONE),
        .Y     (Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [LEN-1:0] ref_mul(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return LEN'(p % (64'd1 << LEN));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        @(negedge CLK);
        START = 1'b1;
        A = a;
        B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 'x;
        B = 'x;
    endtask

    // Waits the LEN edges after the START edge; DONE must appear on exactly the last one.
    task automatic wait_done(input string nm, input logic [LEN-1:0] exp);
        logic early;
        early = 1'b0;
        for (int k = 1; k <= STEPS; k++) begin
            @(posedge CLK);
            #1;
            if (k < STEPS && DONE === 1'b1) early = 1'b1;
        end
        check({nm, "_early"}, 32'(early), 32'd0);
        check({nm, "_done"}, 32'(DONE), 32'd1);
        check({nm, "_y"}, 32'(Y), 32'(exp));
    endtask

    task automatic run_op(input string nm, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          input logic [LEN-1:0] exp);
        launch(a, b);
        wait_done(nm, exp);
    endtask

    initial begin
        logic [LEN-1:0] ra;
        logic [LEN-1:0] rb;
        n_vec = 0;
        n_err = 0;
        START = 1'b0;
        A = '0;
        B = '0;

        vecs[0] = '{"mul_3x5",    16'd3,      16'd5,      16'h000F};
        vecs[1] = '{"mul_trunc",  16'd193,    16'd1543,   16'h8B47};
        vecs[2] = '{"mul_ffff",   16'hFFFF,   16'hFFFF,   16'h0001};
        vecs[3] = '{"mul_zero",   16'h0000,   16'h1234,   16'h0000};

        // Reset held two cycles
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("idle_done", 32'(DONE), 32'd0);
        check("idle_y", 32'(Y), 32'd0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].y);
            if (i == 0) begin
                for (int h = 0; h < 10; h++) begin
                    @(posedge CLK);
                    #1;
                    check("hold_done", 32'(DONE), 32'd1);
                    check("hold_y", 32'(Y), 32'h000F);
                end
            end
        end

        // Back-to-back: next START the cycle after DONE
        for (int i = 0; i < 100; i++) begin
            ra = LEN'(i * 193);
            rb = LEN'(i * 1543);
            run_op("b2b", ra, rb, ref_mul(ra, rb));
        end

        // Restart at E5 with new operands
        launch(16'd7, 16'd9);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1;
        A = 16'd2;
        B = 16'd11;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 'x;
        B = 'x;
        check("restart_busy", 32'(DONE), 32'd0);
        wait_done("restart", 16'h0016);

        // Reset at E8 of an operation in flight
        launch(16'h00FF, 16'h0101);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_y", 32'(Y), 32'd0);
        repeat (20) @(posedge CLK);
        #1;
        check("midrst_stays", 32'(DONE), 32'd0);
        run_op("after_rst", 16'd4, 16'd4, 16'h0010);

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = LEN'($urandom);
            rb = LEN'($urandom);
            if (i % 8 == 0) rb = 16'hFFFF;
            run_op("rand", ra, rb, ref_mul(ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
